// File: rtl/apb4_mux_pkg.sv
// Shared types and helpers for the APB4 peripheral interconnect.
package apb4_mux_pkg;

  // Transfer tracking: IDLE waits for a SETUP phase; ACCESS lasts until PREADY.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Encoding reported on err_type.
  typedef enum logic {
    ERR_UNMAPPED = 1'b0,
    ERR_TIMEOUT  = 1'b1
  } err_type_t;

  // Width of a register holding a slot index; never narrower than one bit.
  function automatic int slot_idx_w(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/apb4_xfer_watchdog.sv
// Wait-state watchdog: counts ACCESS cycles without PREADY and raises abort
// on the cycle after the limit is reached, unless the slave answers then.
module apb4_xfer_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic active,
  input  logic ready,
  output logic abort
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Count stalled ACCESS cycles; cleared whenever no mapped transfer is active, saturates at LIMIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (!ready && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // A zero limit disables the abort entirely; a ready slave always beats the abort.
  assign abort = (TIMEOUT_CYCLES != 0) & active & ~ready & (count == LIMIT);

endmodule

// File: rtl/apb4_periph_mux.sv
// APB4 1-to-N peripheral interconnect: slot decode, request fan-out,
// response mux, unmapped-slot error, wait-state timeout and error capture.
//
// Handshake: a transfer completes upstream on the ACCESS cycle where
// s_PREADY = 1; s_PSLVERR and s_PRDATA are valid only in that cycle.
// Downstream, slot i sees a transfer while m_PSEL[i] = 1 and completes it
// with m_PREADY[i]; an aborted transfer drops m_PSEL in its final cycle.
module apb4_periph_mux
  import apb4_mux_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int PADDR_SIZE     = 12,
  parameter int PDATA_SIZE     = 32,
  parameter int SLOT_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             s_PSEL,
  input  logic                             s_PENABLE,
  input  logic                             s_PWRITE,
  input  logic [2:0]                       s_PPROT,
  input  logic [PDATA_SIZE/8-1:0]          s_PSTRB,
  input  logic [PADDR_SIZE-1:0]            s_PADDR,
  input  logic [PDATA_SIZE-1:0]            s_PWDATA,
  output logic [PDATA_SIZE-1:0]            s_PRDATA,
  output logic                             s_PREADY,
  output logic                             s_PSLVERR,
  output logic [NUM_SLAVES-1:0]            m_PSEL,
  output logic                             m_PENABLE,
  output logic                             m_PWRITE,
  output logic [2:0]                       m_PPROT,
  output logic [PDATA_SIZE/8-1:0]          m_PSTRB,
  output logic [SLOT_BITS-1:0]             m_PADDR,
  output logic [PDATA_SIZE-1:0]            m_PWDATA,
  input  logic [NUM_SLAVES*PDATA_SIZE-1:0] m_PRDATA,
  input  logic [NUM_SLAVES-1:0]            m_PREADY,
  input  logic [NUM_SLAVES-1:0]            m_PSLVERR,
  input  logic                             err_clr,
  output logic                             err_valid,
  output logic                             err_type,
  output logic [PADDR_SIZE-1:0]            err_addr
);

  localparam int IW = slot_idx_w(NUM_SLAVES);
  localparam int XW = PADDR_SIZE - SLOT_BITS;

  state_t                  state;
  logic [IW-1:0]           sel_q;
  logic                    hit_q;
  logic [XW-1:0]           idx;
  logic [31:0]             idx_ext;
  logic                    hit;
  logic                    abort;
  logic                    sel_ready;
  logic                    sel_err;
  logic [PDATA_SIZE-1:0]   sel_rdata;
  logic                    err_event;
  err_type_t               err_kind;
  err_type_t               err_type_q;

  // Broadcast request signals; only the slot-local address bits go downstream.
  assign m_PENABLE = s_PENABLE;
  assign m_PWRITE  = s_PWRITE;
  assign m_PPROT   = s_PPROT;
  assign m_PSTRB   = s_PSTRB;
  assign m_PWDATA  = s_PWDATA;
  assign m_PADDR   = s_PADDR[SLOT_BITS-1:0];

  assign idx     = s_PADDR[PADDR_SIZE-1:SLOT_BITS];
  assign idx_ext = 32'(idx);
  assign hit     = (idx_ext < 32'(NUM_SLAVES));

  // Live decode of the current address into one-hot selects, masked during an abort.
  always_comb begin
    m_PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      m_PSEL[i] = s_PSEL & hit & (idx_ext == 32'(i)) & ~abort;
    end
  end

  // Pick the response of the slot latched at SETUP.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IW'(i)) begin
        sel_ready = m_PREADY[i];
        sel_err   = m_PSLVERR[i];
        sel_rdata = m_PRDATA[i*PDATA_SIZE +: PDATA_SIZE];
      end
    end
  end

  // Transfer FSM: latch the slot at SETUP, return to IDLE once the upstream completes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      sel_q <= '0;
      hit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_PSEL && !s_PENABLE) begin
            state <= ACCESS;
            sel_q <= IW'(idx);
            hit_q <= hit;
          end
        end
        ACCESS: begin
          if (s_PREADY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb4_xfer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK   (CLK),
    .RESET (RESET),
    .active((state == ACCESS) & hit_q),
    .ready (sel_ready),
    .abort (abort)
  );

  // Upstream response: local error for unmapped or aborted transfers, else the slot's answer.
  always_comb begin
    s_PREADY  = 1'b0;
    s_PSLVERR = 1'b0;
    s_PRDATA  = '0;
    if (state == ACCESS) begin
      if (!hit_q || abort) begin
        s_PREADY  = 1'b1;
        s_PSLVERR = 1'b1;
      end else begin
        s_PREADY  = sel_ready;
        s_PSLVERR = sel_err;
        s_PRDATA  = sel_rdata;
      end
    end
  end

  assign err_event = (state == ACCESS) & (~hit_q | abort);
  assign err_kind  = hit_q ? ERR_TIMEOUT : ERR_UNMAPPED;

  // Sticky first-error capture; a new error in the clearing cycle is still recorded.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_valid  <= 1'b0;
      err_type_q <= ERR_UNMAPPED;
      err_addr   <= '0;
    end else if (err_event && (!err_valid || err_clr)) begin
      err_valid  <= 1'b1;
      err_type_q <= err_kind;
      err_addr   <= s_PADDR;
    end else if (err_clr) begin
      err_valid  <= 1'b0;
      err_type_q <= ERR_UNMAPPED;
      err_addr   <= '0;
    end
  end

  assign err_type = err_type_q;

endmodule

// File: tb/tb_apb4_periph_mux.sv
// Directed bench for apb4_periph_mux. Instance u_a uses an 8-cycle timeout,
// instance u_b a 4-cycle timeout; both share every input.
module tb_apb4_periph_mux;

  localparam int NS = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SB = 8;

  logic              CLK;
  logic              RESET;
  logic              s_PSEL, s_PENABLE, s_PWRITE;
  logic [2:0]        s_PPROT;
  logic [DW/8-1:0]   s_PSTRB;
  logic [AW-1:0]     s_PADDR;
  logic [DW-1:0]     s_PWDATA;
  logic [NS*DW-1:0]  m_PRDATA;
  logic [NS-1:0]     m_PREADY, m_PSLVERR;
  logic              err_clr;

  logic [DW-1:0]     a_s_PRDATA, b_s_PRDATA;
  logic              a_s_PREADY, b_s_PREADY, a_s_PSLVERR, b_s_PSLVERR;
  logic [NS-1:0]     a_m_PSEL, b_m_PSEL;
  logic              a_m_PENABLE, b_m_PENABLE, a_m_PWRITE, b_m_PWRITE;
  logic [2:0]        a_m_PPROT, b_m_PPROT;
  logic [DW/8-1:0]   a_m_PSTRB, b_m_PSTRB;
  logic [SB-1:0]     a_m_PADDR, b_m_PADDR;
  logic [DW-1:0]     a_m_PWDATA, b_m_PWDATA;
  logic              a_err_valid, b_err_valid, a_err_type, b_err_type;
  logic [AW-1:0]     a_err_addr, b_err_addr;

  int compared;
  int mismatched;

  apb4_periph_mux #(.NUM_SLAVES(NS), .PADDR_SIZE(AW), .PDATA_SIZE(DW), .SLOT_BITS(SB), .TIMEOUT_CYCLES(8)) u_a (
    .CLK(CLK), .RESET(RESET),
    .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE), .s_PPROT(s_PPROT),
    .s_PSTRB(s_PSTRB), .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA),
    .s_PRDATA(a_s_PRDATA), .s_PREADY(a_s_PREADY), .s_PSLVERR(a_s_PSLVERR),
    .m_PSEL(a_m_PSEL), .m_PENABLE(a_m_PENABLE), .m_PWRITE(a_m_PWRITE), .m_PPROT(a_m_PPROT),
    .m_PSTRB(a_m_PSTRB), .m_PADDR(a_m_PADDR), .m_PWDATA(a_m_PWDATA),
    .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR),
    .err_clr(err_clr), .err_valid(a_err_valid), .err_type(a_err_type), .err_addr(a_err_addr)
  );

  apb4_periph_mux #(.NUM_SLAVES(NS), .PADDR_SIZE(AW), .PDATA_SIZE(DW), .SLOT_BITS(SB), .TIMEOUT_CYCLES(4)) u_b (
    .CLK(CLK), .RESET(RESET),
    .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE), .s_PPROT(s_PPROT),
    .s_PSTRB(s_PSTRB), .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA),
    .s_PRDATA(b_s_PRDATA), .s_PREADY(b_s_PREADY), .s_PSLVERR(b_s_PSLVERR),
    .m_PSEL(b_m_PSEL), .m_PENABLE(b_m_PENABLE), .m_PWRITE(b_m_PWRITE), .m_PPROT(b_m_PPROT),
    .m_PSTRB(b_m_PSTRB), .m_PADDR(b_m_PADDR), .m_PWDATA(b_m_PWDATA),
    .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR),
    .err_clr(err_clr), .err_valid(b_err_valid), .err_type(b_err_type), .err_addr(b_err_addr)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic bus_idle();
    s_PSEL    = 1'b0;
    s_PENABLE = 1'b0;
    m_PREADY  = '0;
    m_PSLVERR = '0;
  endtask

  // SETUP phase on the next cycle.
  task automatic drive_setup(input logic [AW-1:0] addr, input logic write);
    step();
    s_PSEL    = 1'b1;
    s_PENABLE = 1'b0;
    s_PWRITE  = write;
    s_PADDR   = addr;
  endtask

  // Move into the first ACCESS cycle.
  task automatic drive_access();
    step();
    s_PENABLE = 1'b1;
  endtask

  task automatic pulse_err_clr();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    sample();
    compared++; if (a_s_PREADY !== 1'b0) begin mismatched++; $display("FAIL reset_pready: got %0h expected 0", a_s_PREADY); end
    compared++; if (a_s_PSLVERR !== 1'b0) begin mismatched++; $display("FAIL reset_pslverr: got %0h expected 0", a_s_PSLVERR); end
    compared++; if (a_s_PRDATA !== 32'h0) begin mismatched++; $display("FAIL reset_prdata: got %08h expected 0", a_s_PRDATA); end
    compared++; if (a_m_PSEL !== 4'b0000) begin mismatched++; $display("FAIL reset_psel: got %04b expected 0000", a_m_PSEL); end
    compared++; if ({a_err_valid, a_err_type, a_err_addr} !== 14'h0) begin mismatched++; $display("FAIL reset_err: got v=%0h t=%0h a=%03h expected all 0", a_err_valid, a_err_type, a_err_addr); end
    step();
    RESET = 1'b0;
    // Reset in the middle of an ACCESS to slot 2.
    drive_setup(12'h210, 1'b0);
    drive_access();
    sample();
    compared++; if (a_m_PSEL !== 4'b0100) begin mismatched++; $display("FAIL midreset_psel_before: got %04b expected 0100", a_m_PSEL); end
    RESET = 1'b1;
    bus_idle();
    step();
    RESET = 1'b0;
    sample();
    compared++; if (a_m_PSEL !== 4'b0000) begin mismatched++; $display("FAIL midreset_psel: got %04b expected 0000", a_m_PSEL); end
    compared++; if (a_s_PREADY !== 1'b0) begin mismatched++; $display("FAIL midreset_pready: got %0h expected 0", a_s_PREADY); end
    compared++; if (a_err_valid !== 1'b0) begin mismatched++; $display("FAIL midreset_err_valid: got %0h expected 0", a_err_valid); end
  endtask

  task automatic test_read_slot1();
    drive_setup(12'h1A4, 1'b0);
    sample();
    compared++; if (a_m_PSEL !== 4'b0010) begin mismatched++; $display("FAIL rd1_setup_psel: got %04b expected 0010", a_m_PSEL); end
    compared++; if (a_m_PADDR !== 8'hA4) begin mismatched++; $display("FAIL rd1_paddr: got %02h expected a4", a_m_PADDR); end
    compared++; if (a_s_PREADY !== 1'b0) begin mismatched++; $display("FAIL rd1_setup_pready: got %0h expected 0", a_s_PREADY); end
    drive_access();
    for (int k = 1; k <= 2; k++) begin
      sample();
      compared++; if (a_s_PREADY !== 1'b0) begin mismatched++; $display("FAIL rd1_wait%0d_pready: got %0h expected 0", k, a_s_PREADY); end
      step();
    end
    m_PREADY = 4'b0010;
    sample();
    compared++; if (a_s_PREADY !== 1'b1) begin mismatched++; $display("FAIL rd1_pready: got %0h expected 1", a_s_PREADY); end
    compared++; if (a_s_PRDATA !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd1_prdata: got %08h expected deadbeef", a_s_PRDATA); end
    compared++; if (a_s_PSLVERR !== 1'b0) begin mismatched++; $display("FAIL rd1_pslverr: got %0h expected 0", a_s_PSLVERR); end
    compared++; if ({a_m_PSEL, a_m_PENABLE, a_m_PWRITE} !== 6'b0010_1_0) begin mismatched++; $display("FAIL rd1_ctrl: got psel=%04b en=%0h wr=%0h expected 0010 1 0", a_m_PSEL, a_m_PENABLE, a_m_PWRITE); end
    step();
    bus_idle();
    sample();
    compared++; if (a_err_valid !== 1'b0) begin mismatched++; $display("FAIL rd1_err_valid: got %0h expected 0", a_err_valid); end
  endtask

  task automatic test_unmapped_write();
    drive_setup(12'h7F0, 1'b1);
    s_PWDATA = 32'hCAFEF00D;
    s_PSTRB  = 4'b1010;
    s_PPROT  = 3'b101;
    sample();
    compared++; if (a_m_PSEL !== 4'b0000) begin mismatched++; $display("FAIL unm_psel: got %04b expected 0000", a_m_PSEL); end
    compared++; if ({a_m_PWDATA, a_m_PSTRB, a_m_PPROT, a_m_PWRITE, a_m_PADDR} !== {32'hCAFEF00D, 4'b1010, 3'b101, 1'b1, 8'hF0}) begin
      mismatched++; $display("FAIL unm_broadcast: got wd=%08h st=%04b pr=%03b wr=%0h ad=%02h expected cafef00d 1010 101 1 f0", a_m_PWDATA, a_m_PSTRB, a_m_PPROT, a_m_PWRITE, a_m_PADDR);
    end
    drive_access();
    sample();
    compared++; if ({a_s_PREADY, a_s_PSLVERR} !== 2'b11) begin mismatched++; $display("FAIL unm_resp: got rdy=%0h err=%0h expected 1 1", a_s_PREADY, a_s_PSLVERR); end
    compared++; if (a_s_PRDATA !== 32'h0) begin mismatched++; $display("FAIL unm_prdata: got %08h expected 0", a_s_PRDATA); end
    step();
    bus_idle();
    sample();
    compared++; if ({a_err_valid, a_err_type, a_err_addr} !== {1'b1, 1'b0, 12'h7F0}) begin mismatched++; $display("FAIL unm_capture: got v=%0h t=%0h a=%03h expected 1 0 7f0", a_err_valid, a_err_type, a_err_addr); end
  endtask

  task automatic test_timeout();
    pulse_err_clr();
    sample();
    compared++; if (a_err_valid !== 1'b0) begin mismatched++; $display("FAIL clr_err_valid: got %0h expected 0", a_err_valid); end
    drive_setup(12'h3C8, 1'b0);
    drive_access();
    for (int k = 1; k <= 8; k++) begin
      sample();
      compared++; if ({a_s_PREADY, a_m_PSEL} !== 5'b0_1000) begin mismatched++; $display("FAIL to_wait%0d: got rdy=%0h psel=%04b expected 0 1000", k, a_s_PREADY, a_m_PSEL); end
      step();
    end
    sample();
    compared++; if ({a_s_PREADY, a_s_PSLVERR} !== 2'b11) begin mismatched++; $display("FAIL to_abort_resp: got rdy=%0h err=%0h expected 1 1", a_s_PREADY, a_s_PSLVERR); end
    compared++; if (a_m_PSEL !== 4'b0000) begin mismatched++; $display("FAIL to_abort_psel: got %04b expected 0000", a_m_PSEL); end
    compared++; if (a_s_PRDATA !== 32'h0) begin mismatched++; $display("FAIL to_abort_prdata: got %08h expected 0", a_s_PRDATA); end
    step();
    bus_idle();
    sample();
    compared++; if ({a_err_valid, a_err_type, a_err_addr} !== {1'b1, 1'b1, 12'h3C8}) begin mismatched++; $display("FAIL to_capture: got v=%0h t=%0h a=%03h expected 1 1 3c8", a_err_valid, a_err_type, a_err_addr); end
  endtask

  task automatic test_first_error_wins();
    drive_setup(12'h500, 1'b0);
    drive_access();
    sample();
    compared++; if ({a_s_PREADY, a_s_PSLVERR} !== 2'b11) begin mismatched++; $display("FAIL few_resp: got rdy=%0h err=%0h expected 1 1", a_s_PREADY, a_s_PSLVERR); end
    step();
    bus_idle();
    sample();
    compared++; if ({a_err_valid, a_err_type, a_err_addr} !== {1'b1, 1'b1, 12'h3C8}) begin mismatched++; $display("FAIL few_keep: got v=%0h t=%0h a=%03h expected 1 1 3c8", a_err_valid, a_err_type, a_err_addr); end
    // Timeout to slot 2 with err_clr in the abort cycle.
    drive_setup(12'h2AC, 1'b1);
    drive_access();
    for (int k = 1; k <= 8; k++) step();
    err_clr = 1'b1;
    sample();
    compared++; if ({a_s_PREADY, a_s_PSLVERR} !== 2'b11) begin mismatched++; $display("FAIL clrto_resp: got rdy=%0h err=%0h expected 1 1", a_s_PREADY, a_s_PSLVERR); end
    step();
    err_clr = 1'b0;
    bus_idle();
    sample();
    compared++; if ({a_err_valid, a_err_type, a_err_addr} !== {1'b1, 1'b1, 12'h2AC}) begin mismatched++; $display("FAIL clrto_capture: got v=%0h t=%0h a=%03h expected 1 1 2ac", a_err_valid, a_err_type, a_err_addr); end
  endtask

  task automatic test_back_to_back();
    pulse_err_clr();
    sample();
    compared++; if (b_err_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_clr: got %0h expected 0", b_err_valid); end
    drive_setup(12'h010, 1'b0);
    sample();
    compared++; if (b_m_PSEL !== 4'b0001) begin mismatched++; $display("FAIL b2b_setup0_psel: got %04b expected 0001", b_m_PSEL); end
    drive_access();
    for (int k = 1; k <= 4; k++) begin
      sample();
      compared++; if (b_s_PREADY !== 1'b0) begin mismatched++; $display("FAIL b2b_wait%0d: got %0h expected 0", k, b_s_PREADY); end
      step();
    end
    m_PREADY = 4'b0001;
    sample();
    compared++; if ({b_s_PREADY, b_s_PSLVERR} !== 2'b10) begin mismatched++; $display("FAIL coincide_resp: got rdy=%0h err=%0h expected 1 0", b_s_PREADY, b_s_PSLVERR); end
    compared++; if (b_s_PRDATA !== 32'h11110000) begin mismatched++; $display("FAIL coincide_prdata: got %08h expected 11110000", b_s_PRDATA); end
    compared++; if (b_m_PSEL !== 4'b0001) begin mismatched++; $display("FAIL coincide_psel: got %04b expected 0001", b_m_PSEL); end
    drive_setup(12'h104, 1'b0);
    m_PREADY = '0;
    sample();
    compared++; if ({b_m_PSEL, b_s_PREADY} !== 5'b0010_0) begin mismatched++; $display("FAIL b2b_setup1: got psel=%04b rdy=%0h expected 0010 0", b_m_PSEL, b_s_PREADY); end
    drive_access();
    m_PREADY = 4'b0010;
    sample();
    compared++; if ({b_s_PREADY, b_s_PSLVERR, b_s_PRDATA} !== {2'b10, 32'hDEADBEEF}) begin mismatched++; $display("FAIL b2b_resp1: got rdy=%0h err=%0h d=%08h expected 1 0 deadbeef", b_s_PREADY, b_s_PSLVERR, b_s_PRDATA); end
    step();
    bus_idle();
    sample();
    compared++; if ({b_err_valid, a_err_valid} !== 2'b00) begin mismatched++; $display("FAIL b2b_no_capture: got b=%0h a=%0h expected 0 0", b_err_valid, a_err_valid); end
  endtask

  task automatic test_slave_err();
    drive_setup(12'h2F0, 1'b0);
    drive_access();
    m_PREADY  = 4'b0100;
    m_PSLVERR = 4'b0100;
    sample();
    compared++; if ({a_s_PREADY, a_s_PSLVERR, a_s_PRDATA} !== {2'b11, 32'h22222222}) begin mismatched++; $display("FAIL slverr_resp: got rdy=%0h err=%0h d=%08h expected 1 1 22222222", a_s_PREADY, a_s_PSLVERR, a_s_PRDATA); end
    step();
    bus_idle();
    sample();
    compared++; if (a_err_valid !== 1'b0) begin mismatched++; $display("FAIL slverr_no_capture: got %0h expected 0", a_err_valid); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    RESET      = 1'b1;
    s_PSEL     = 1'b0;
    s_PENABLE  = 1'b0;
    s_PWRITE   = 1'b0;
    s_PPROT    = 3'b000;
    s_PSTRB    = 4'b1111;
    s_PADDR    = '0;
    s_PWDATA   = '0;
    m_PRDATA   = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11110000};
    m_PREADY   = '0;
    m_PSLVERR  = '0;
    err_clr    = 1'b0;
    test_reset();
    test_read_slot1();
    test_unmapped_write();
    test_timeout();
    test_first_error_wins();
    test_back_to_back();
    test_slave_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
